imem_boot_loader: RTL and testbench

//  Writer side of the instruction-memory port: takes a byte stream (valid/ready), packs

---
 rtl/imem_boot_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a length-prefixed little-endian byte stream into 32-bit imem writes
// and holds the core in reset until the image is loaded. Optional trailing XOR checksum: IMEM_LOADER_CHKSUM_EN.
module imem_boot_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;
`ifdef IMEM_LOADER_CHKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd5;
    localparam logic [2:0] S_FINAL = S_CHK;
`else
    localparam logic [2:0] S_FINAL = S_DONE;
`endif

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] word_count_q, word_count_d;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] word_count_inc;

    assign xfer           = byte_valid && byte_ready;
    assign len_full       = {byte_data, len_q[7:0]};
    assign word_count_inc = word_count_q + 16'd1;

    // NOTE: every variable gets a default at the top of always_comb, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
`ifdef IMEM_LOADER_CHKSUM_EN
        chk_d        = chk_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_LEN0;
                    len_d        = 16'd0;
                    idx_d        = 2'd0;
                    word_count_d = 16'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d        = 8'd0;
`endif
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d[15:8] = byte_data;
                    idx_d       = 2'd0;
                    if (len_full == 16'd0) begin
                        state_d = S_FINAL;
                    end else if ({1'b0, len_full} > 17'(DEPTH_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    acc_d[{idx_q, 3'b000} +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d = chk_q ^ byte_data;
`endif
                    if (idx_q == 2'd3) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = acc_d;
                        mem_addr_d  = BASE_ADDR + {14'd0, word_count_q, 2'b00};
                    end
                end
            end
            S_WRITE: begin
                word_count_d = word_count_inc;
                state_d      = (word_count_inc == len_q) ? S_FINAL : S_DATA;
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d = (byte_data == chk_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            idx_q        <= 2'd0;
            acc_q        <= 32'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            word_count_q <= 16'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    // Status outputs decode the registered state directly, so cpu_rst_n rises in the first DONE cycle.
`ifdef IMEM_LOADER_CHKSUM_EN
    assign byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                        (state_q == S_DATA) || (state_q == S_CHK);
`else
    assign byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
`endif
    assign busy       = byte_ready || (state_q == S_WRITE);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign cpu_rst_n  = (state_q == S_DONE);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for imem_boot_loader: expected imem writes are queued at
// stimulus time and a negedge monitor pops and compares each mem_we pulse.
module tb_imem_boot_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, mem_we, cpu_rst_n, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] word_count;

    imem_boot_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          we_pulses = 0;
    logic [31:0] img [0:299];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_pulses++;
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int t;
        t = 0;
        while (gap_pct > 0 && t < 8 && $urandom_range(0, 99) < gap_pct) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(posedge clk); #1;
            t++;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!byte_ready) begin
            check("byte_ready_timeout", 32'd0, 32'd1);
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_status();
        int t;
        t = 0;
        while (!(done || err) && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!(done || err)) check("status_timeout", 32'd0, 32'd1);
    endtask

    // Reference: an N-word image at or under capacity produces writes at BASE+4*i with the
    // image words, then done (or err on checksum mismatch); an oversize length gives err only.
    task automatic run_load(input int n, input int gap_pct, input bit bad_chk, input bit poke_start);
        int   pulses0;
        bit   exp_err;
        int   exp_wc;
        logic [7:0] x;
        logic [31:0] w;
        x = 8'h00;
        exp_err = (n > DEPTH);
`ifdef IMEM_LOADER_CHKSUM_EN
        if (n <= DEPTH && bad_chk) exp_err = 1'b1;
`endif
        exp_wc  = (n > DEPTH) ? 0 : n;
        pulses0 = we_pulses;

        pulse_start();
        check("start_done", 32'(done), 32'd0);
        check("start_err", 32'(err), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("start_word_count", 32'(word_count), 32'd0);

        if (n <= DEPTH)
            for (int i = 0; i < n; i++) sb.push_back({BASE + 32'(4 * i), img[i]});

        send_byte(8'(n), gap_pct);
        send_byte(8'(n >> 8), gap_pct);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                w = img[i];
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8], gap_pct);
                    x = x ^ w[8*k +: 8];
                    if (poke_start && i == 0 && k == 0) begin
                        pulse_start();
                        check("poke_busy", 32'(busy), 32'd1);
                        check("poke_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
                    end
                end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            send_byte(bad_chk ? (x ^ 8'h01) : x, gap_pct);
`endif
        end
        wait_status();
        check("end_done", 32'(done), 32'(!exp_err));
        check("end_err", 32'(err), 32'(exp_err));
        check("end_cpu_rst_n", 32'(cpu_rst_n), 32'(!exp_err));
        check("end_busy", 32'(busy), 32'd0);
        check("end_byte_ready", 32'(byte_ready), 32'd0);
        check("end_word_count", 32'(word_count), 32'(exp_wc));
        check("we_pulses", 32'(we_pulses - pulses0), 32'(exp_wc));
        check("sb_drained", 32'(sb.size()), 32'd0);
        if (exp_wc > 0) begin
            check("hold_addr", mem_addr, BASE + 32'(4 * (exp_wc - 1)));
            check("hold_data", mem_wdata, img[exp_wc - 1]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed two-word image.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        run_load(2, 0, 1'b0, 1'b0);

        // Async reset in the middle of a word: nothing written, everything back to reset values.
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_mem_wdata", mem_wdata, 32'd0);
        check("mid_rst_word_count", 32'(word_count), 32'd0);
        check("mid_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_done_err", {30'd0, done, err}, 32'd0);

        // Oversize length 0x0101.
        run_load(257, 0, 1'b0, 1'b0);

        // Three words with 50% valid gaps.
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        run_load(3, 50, 1'b0, 1'b0);

        // start while busy is ignored; the subsequent start from DONE reloads.
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        run_load(4, 0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) img[i] = $urandom;
        run_load(2, 25, 1'b0, 1'b0);

        // Empty image, full-capacity image, random short images.
        run_load(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        run_load(DEPTH, 0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_load(n, (r % 2 == 0) ? 50 : 0, 1'b0, 1'b0);
        end

`ifdef IMEM_LOADER_CHKSUM_EN
        img[0] = 32'h4433_2211;
        run_load(1, 0, 1'b0, 1'b0);
        run_load(1, 0, 1'b1, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
